// File: rtl/axi4_stream_rx_fifo.sv
// AXI4-Stream slave sink: registered TREADY backpressure into a DEPTH-entry FWFT FIFO.
// Optional sticky source-protocol checker enabled by AXI4_STREAM_RX_PROTOCOL_CHECK_EN.
module axi4_stream_rx_fifo #(
    parameter int DATA_BYTES     = 16,
    parameter int TUSER_WIDTH    = 16,
    parameter int DEPTH          = 8,
    parameter int HIGH_WATERMARK = 6
) (
    input  logic                      ACLK,
    input  logic                      ARESET_N,
    input  logic                      TVALID,
    output logic                      TREADY,
    input  logic [8*DATA_BYTES-1:0]   TDATA,
    input  logic [TUSER_WIDTH-1:0]    TUSER,
    input  logic                      RD_EN,
    output logic                      RD_VALID,
    output logic [8*DATA_BYTES-1:0]   RD_DATA,
    output logic [TUSER_WIDTH-1:0]    RD_USER,
    output logic [$clog2(DEPTH):0]    FILL_LEVEL,
`ifdef AXI4_STREAM_RX_PROTOCOL_CHECK_EN
    output logic                      PROTO_ERR,
`endif
    output logic                      ALMOST_FULL
);

    localparam int DW = 8 * DATA_BYTES;
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [DW-1:0]          data_mem [DEPTH];
    logic [TUSER_WIDTH-1:0] user_mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          tready_q, tready_d;
    logic          push, pop;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        push     = TVALID & tready_q;
        pop      = RD_EN & (fill_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        fill_d   = fill_q + FW'(push) - FW'(pop);
        tready_d = (fill_d < FW'(DEPTH));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            tready_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            tready_q <= tready_d;
        end
    end

    // NOTE: storage is not reset; its contents are only observable once fill marks them valid.
    always_ff @(posedge ACLK) begin
        if (push) begin
            data_mem[wr_ptr_q] <= TDATA;
            user_mem[wr_ptr_q] <= TUSER;
        end
    end

    assign TREADY      = tready_q;
    assign RD_VALID    = (fill_q != '0);
    assign RD_DATA     = data_mem[rd_ptr_q];
    assign RD_USER     = user_mem[rd_ptr_q];
    assign FILL_LEVEL  = fill_q;
    assign ALMOST_FULL = (fill_q >= FW'(HIGH_WATERMARK));

`ifdef AXI4_STREAM_RX_PROTOCOL_CHECK_EN
    // A stalled beat must be held stable until it is accepted.
    logic                   chk_pend_q;
    logic [DW-1:0]          chk_data_q;
    logic [TUSER_WIDTH-1:0] chk_user_q;
    logic                   proto_err_q;
    logic                   stall;
    logic                   violation;

    always_comb begin
        stall     = TVALID & ~tready_q;
        violation = chk_pend_q &
                    (~TVALID | (TDATA != chk_data_q) | (TUSER != chk_user_q));
    end

    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            chk_pend_q  <= 1'b0;
            chk_data_q  <= '0;
            chk_user_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            chk_pend_q <= stall;
            if (stall) begin
                chk_data_q <= TDATA;
                chk_user_q <= TUSER;
            end
            if (violation) proto_err_q <= 1'b1;
        end
    end

    assign PROTO_ERR = proto_err_q;
`endif

endmodule
